// File: rtl/ysyx_22040386_trap_ctrl.sv
// Machine-mode trap entry/return sequencer at the writeback boundary; owns the CSR write port.
// Optional MTVEC_VECTORED_EN: vectored mtvec targets for interrupt causes.
module ysyx_22040386_trap_ctrl #(
    parameter int CSR_W = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_WB_valid,
    input  logic             i_WB_ecall,
    input  logic             i_WB_mret,
    input  logic             i_WB_timer_intr,
    input  logic [CSR_W-1:0] i_WB_pc,
    input  logic [CSR_W-1:0] i_WB_next_pc,
    input  logic             i_WB_csr_wen,
    input  logic [11:0]      i_WB_csr_waddr,
    input  logic [CSR_W-1:0] i_WB_csr_wdata,
    input  logic [CSR_W-1:0] i_mstatus,
    input  logic [CSR_W-1:0] i_mie,
    input  logic [CSR_W-1:0] i_mtvec,
    input  logic [CSR_W-1:0] i_mepc,
    output logic             o_csr_wen,
    output logic [11:0]      o_csr_waddr,
    output logic [CSR_W-1:0] o_csr_wdata,
    output logic             o_stall,
    output logic             o_flush,
    output logic             o_redirect,
    output logic [CSR_W-1:0] o_redirect_pc,
    output logic             o_busy
);

    typedef enum logic [2:0] {IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, W_MRET, REDIRECT} state_t;

    localparam logic [11:0]      ADDR_MSTATUS = 12'h300;
    localparam logic [11:0]      ADDR_MEPC    = 12'h341;
    localparam logic [11:0]      ADDR_MCAUSE  = 12'h342;
    localparam logic [CSR_W-1:0] CAUSE_ECALL  = CSR_W'(11);
    localparam logic [CSR_W-1:0] CAUSE_TIMER  = {1'b1, (CSR_W-1)'(7)};

    state_t           state;
    logic [CSR_W-1:0] mepc_q;
    logic [CSR_W-1:0] cause_q;

    logic             timer_take;
    logic             trig_trap;
    logic             trig_ret;
    logic             trigger;
    logic [CSR_W-1:0] ms_trap;
    logic [CSR_W-1:0] ms_ret;
    logic [CSR_W-1:0] trap_tgt;

    // ecall and mret outrank the interrupt; a masked interrupt waits for a later IDLE cycle
    assign timer_take = i_WB_timer_intr & i_mstatus[3] & i_mie[7];
    assign trig_trap  = i_WB_valid & (i_WB_ecall | (~i_WB_mret & timer_take));
    assign trig_ret   = i_WB_valid & ~i_WB_ecall & i_WB_mret;
    assign trigger    = (state == IDLE) & (trig_trap | trig_ret);

    assign o_stall = i_rst_n & (trigger | (state != IDLE));

    always_comb begin
        ms_trap        = i_mstatus;
        ms_trap[7]     = i_mstatus[3];
        ms_trap[3]     = 1'b0;
        ms_trap[12:11] = 2'b11;
        ms_ret         = i_mstatus;
        ms_ret[3]      = i_mstatus[7];
        ms_ret[7]      = 1'b1;
        ms_ret[12:11]  = 2'b11;
    end

`ifdef MTVEC_VECTORED_EN
    always_comb begin
        trap_tgt = {i_mtvec[CSR_W-1:2], 2'b00};
        if (cause_q[CSR_W-1] && (i_mtvec[1:0] == 2'b01))
            trap_tgt = trap_tgt + CSR_W'({cause_q[5:0], 2'b00});
    end
    logic unused_bits;
    assign unused_bits = &{1'b0, i_mie[CSR_W-1:8], i_mie[6:0]};
`else
    assign trap_tgt = {i_mtvec[CSR_W-1:2], 2'b00};
    logic unused_bits;
    assign unused_bits = &{1'b0, i_mie[CSR_W-1:8], i_mie[6:0], i_mtvec[1:0]};
`endif

    // The port is WB's in IDLE (trigger cycle included) and the sequencer's otherwise
    always_comb begin
        o_csr_wen   = 1'b0;
        o_csr_waddr = 12'h0;
        o_csr_wdata = '0;
        if (i_rst_n) begin
            case (state)
                IDLE: begin
                    o_csr_wen   = i_WB_csr_wen;
                    o_csr_waddr = i_WB_csr_waddr;
                    o_csr_wdata = i_WB_csr_wdata;
                end
                W_MEPC:    begin o_csr_wen = 1'b1; o_csr_waddr = ADDR_MEPC;    o_csr_wdata = mepc_q;  end
                W_MCAUSE:  begin o_csr_wen = 1'b1; o_csr_waddr = ADDR_MCAUSE;  o_csr_wdata = cause_q; end
                W_MSTATUS: begin o_csr_wen = 1'b1; o_csr_waddr = ADDR_MSTATUS; o_csr_wdata = ms_trap; end
                W_MRET:    begin o_csr_wen = 1'b1; o_csr_waddr = ADDR_MSTATUS; o_csr_wdata = ms_ret;  end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            mepc_q        <= '0;
            cause_q       <= '0;
            o_flush       <= 1'b0;
            o_redirect    <= 1'b0;
            o_redirect_pc <= '0;
            o_busy        <= 1'b0;
        end else begin
            o_flush    <= 1'b0;
            o_redirect <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig_trap) begin
                        state   <= W_MEPC;
                        o_busy  <= 1'b1;
                        mepc_q  <= i_WB_ecall ? i_WB_pc : i_WB_next_pc;
                        cause_q <= i_WB_ecall ? CAUSE_ECALL : CAUSE_TIMER;
                    end else if (trig_ret) begin
                        state   <= W_MRET;
                        o_busy  <= 1'b1;
                        mepc_q  <= i_WB_pc;
                        cause_q <= '0;
                    end
                end
                W_MEPC:   state <= W_MCAUSE;
                W_MCAUSE: state <= W_MSTATUS;
                W_MSTATUS: begin
                    state         <= REDIRECT;
                    o_redirect    <= 1'b1;
                    o_flush       <= 1'b1;
                    o_redirect_pc <= trap_tgt;
                end
                W_MRET: begin
                    state         <= REDIRECT;
                    o_redirect    <= 1'b1;
                    o_flush       <= 1'b1;
                    o_redirect_pc <= i_mepc;
                end
                default: begin
                    state         <= IDLE;
                    o_busy        <= 1'b0;
                    o_redirect_pc <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040386_trap_ctrl.sv
// Bench for ysyx_22040386_trap_ctrl: directed vector table, randomized run against a queue model, reset corner.
module tb_ysyx_22040386_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v, ec, mr, ti, wen;
    logic [11:0] wa;
    logic [63:0] wd, pc, npc;
    logic [63:0] ms, mie_r, mtvec_r, mepc_r;
    logic        o_csr_wen, o_stall, o_flush, o_redirect, o_busy;
    logic [11:0] o_csr_waddr;
    logic [63:0] o_csr_wdata, o_redirect_pc;

    always #5 clk = ~clk;

    ysyx_22040386_trap_ctrl #(.CSR_W(64)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_WB_valid(v), .i_WB_ecall(ec), .i_WB_mret(mr), .i_WB_timer_intr(ti),
        .i_WB_pc(pc), .i_WB_next_pc(npc),
        .i_WB_csr_wen(wen), .i_WB_csr_waddr(wa), .i_WB_csr_wdata(wd),
        .i_mstatus(ms), .i_mie(mie_r), .i_mtvec(mtvec_r), .i_mepc(mepc_r),
        .o_csr_wen(o_csr_wen), .o_csr_waddr(o_csr_waddr), .o_csr_wdata(o_csr_wdata),
        .o_stall(o_stall), .o_flush(o_flush), .o_redirect(o_redirect),
        .o_redirect_pc(o_redirect_pc), .o_busy(o_busy)
    );

    int errs = 0, checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Small CSR file: a write seen on the port lands before the next cycle's inputs
    logic        pw;
    logic [11:0] pa;
    logic [63:0] pd;

    task automatic drive(input bit iv, iec, imr, iti, iwen, input logic [11:0] iwa,
                         input logic [63:0] iwd, ipc, inpc);
        @(negedge clk);
        if (pw) begin
            case (pa)
                12'h300: ms      = pd;
                12'h304: mie_r   = pd;
                12'h305: mtvec_r = pd;
                12'h341: mepc_r  = pd;
                default: ;
            endcase
        end
        v = iv; ec = iec; mr = imr; ti = iti; wen = iwen; wa = iwa; wd = iwd; pc = ipc; npc = inpc;
        #1;
        pw = o_csr_wen; pa = o_csr_waddr; pd = o_csr_wdata;
    endtask

    // Spec rules written as masks over the four bits each update touches
    function automatic logic [63:0] ms_enter(input logic [63:0] m);
        return (m & ~64'h1888) | (m[3] ? 64'h80 : 64'h0) | 64'h1800;
    endfunction
    function automatic logic [63:0] ms_leave(input logic [63:0] m);
        return (m & ~64'h1888) | (m[7] ? 64'h8 : 64'h0) | 64'h1880;
    endfunction
    function automatic logic [63:0] trap_target(input logic [63:0] cause);
        logic [63:0] t;
        t = mtvec_r & ~64'h3;
`ifdef MTVEC_VECTORED_EN
        if (cause[63] && mtvec_r[1:0] == 2'b01) t = t + 64'(cause[5:0]) * 4;
`else
        if (cause[63]) t = t;
`endif
        return t;
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        bit v, ec, mr, ti, wen;
        logic [11:0] wa;
        logic [63:0] wd;
        bit ew;
        logic [11:0] ea;
        logic [63:0] ed;
        bit es, er;
        logic [63:0] erpc;
    } vec_t;

    function automatic vec_t mk(input bit iv, iec, imr, iti, iwen, input logic [11:0] iwa,
                                input logic [63:0] iwd, input bit ew, input logic [11:0] ea,
                                input logic [63:0] ed, input bit es, er, input logic [63:0] erpc);
        vec_t r;
        r.v = iv; r.ec = iec; r.mr = imr; r.ti = iti; r.wen = iwen; r.wa = iwa; r.wd = iwd;
        r.ew = ew; r.ea = ea; r.ed = ed; r.es = es; r.er = er; r.erpc = erpc;
        return r;
    endfunction

    localparam logic [63:0] PC0  = 64'h8000_0100;
    localparam logic [63:0] NPC0 = 64'h8000_0208;
    localparam logic [63:0] TCAUSE = 64'h8000_0000_0000_0007;

    vec_t tbl[25];

    // ---------------- random model ----------------
    typedef struct {int kind; logic [11:0] a; logic [63:0] d;} step_t;
    step_t q[$];

    function automatic step_t st(input int k, input logic [11:0] a, input logic [63:0] d);
        step_t s;
        s.kind = k; s.a = a; s.d = d;
        return s;
    endfunction

    task automatic rstep(input bit iv, iec, imr, iti, iwen, input logic [11:0] iwa,
                         input logic [63:0] iwd, ipc, inpc);
        step_t e;
        bit trig;
        drive(iv, iec, imr, iti, iwen, iwa, iwd, ipc, inpc);
        if (q.size() == 0) begin
            trig = iv && (iec || imr || (iti && ms[3] && mie_r[7]));
            chk("idle_wen", o_csr_wen, iwen);
            if (iwen) chk("idle_wr", {o_csr_waddr, o_csr_wdata}, {iwa, iwd});
            chk("idle_stall", o_stall, trig);
            chk("idle_ctl", {o_busy, o_redirect, o_flush}, 3'b000);
            if (trig) begin
                if (iec) begin
                    q.push_back(st(0, 12'h341, ipc));
                    q.push_back(st(0, 12'h342, 64'hB));
                    q.push_back(st(1, 12'h300, 0));
                    q.push_back(st(3, 0, 64'hB));
                end else if (imr) begin
                    q.push_back(st(2, 12'h300, 0));
                    q.push_back(st(4, 0, 0));
                end else begin
                    q.push_back(st(0, 12'h341, inpc));
                    q.push_back(st(0, 12'h342, TCAUSE));
                    q.push_back(st(1, 12'h300, 0));
                    q.push_back(st(3, 0, TCAUSE));
                end
            end
        end else begin
            e = q.pop_front();
            chk("seq_stall_busy", {o_stall, o_busy}, 2'b11);
            case (e.kind)
                0: chk("seq_wr", {o_csr_wen, o_csr_waddr, o_csr_wdata, o_redirect}, {1'b1, e.a, e.d, 1'b0});
                1: chk("seq_ms_trap", {o_csr_wen, o_csr_waddr, o_csr_wdata, o_redirect}, {1'b1, 12'h300, ms_enter(ms), 1'b0});
                2: chk("seq_ms_ret", {o_csr_wen, o_csr_waddr, o_csr_wdata, o_redirect}, {1'b1, 12'h300, ms_leave(ms), 1'b0});
                3: begin
                    chk("seq_redir", {o_csr_wen, o_redirect, o_flush}, 3'b011);
                    chk("seq_trap_pc", o_redirect_pc, trap_target(e.d));
                end
                default: begin
                    chk("seq_redir", {o_csr_wen, o_redirect, o_flush}, 3'b011);
                    chk("seq_ret_pc", o_redirect_pc, mepc_r);
                end
            endcase
        end
    endtask

    logic [11:0] addrs[5];

    initial begin
        rst_n = 1'b0; pw = 1'b0; pa = 0; pd = 0;
        v = 0; ec = 0; mr = 0; ti = 0; wen = 0; wa = 0; wd = 0; pc = 0; npc = 0;
        ms = 64'h8; mie_r = 64'h80; mtvec_r = 64'h8000_0400; mepc_r = 0;

        tbl[0]  = mk(1,1,0,0, 0,12'h0,64'h0,           0,12'h0,64'h0,           1,0,64'h0);
        tbl[1]  = mk(0,0,0,0, 0,12'h0,64'h0,           1,12'h341,PC0,           1,0,64'h0);
        tbl[2]  = mk(1,0,0,0, 1,12'h305,64'hDEAD,      1,12'h342,64'hB,         1,0,64'h0);
        tbl[3]  = mk(0,0,0,0, 0,12'h0,64'h0,           1,12'h300,64'h1880,      1,0,64'h0);
        tbl[4]  = mk(0,0,0,0, 0,12'h0,64'h0,           0,12'h0,64'h0,           1,1,64'h8000_0400);
        tbl[5]  = mk(0,0,0,0, 0,12'h0,64'h0,           0,12'h0,64'h0,           0,0,64'h0);
        tbl[6]  = mk(1,0,0,0, 1,12'h341,64'h8000_0104, 1,12'h341,64'h8000_0104, 0,0,64'h0);
        tbl[7]  = mk(1,0,1,0, 0,12'h0,64'h0,           0,12'h0,64'h0,           1,0,64'h0);
        tbl[8]  = mk(0,0,0,0, 0,12'h0,64'h0,           1,12'h300,64'h1888,      1,0,64'h0);
        tbl[9]  = mk(0,0,0,0, 0,12'h0,64'h0,           0,12'h0,64'h0,           1,1,64'h8000_0104);
        tbl[10] = mk(0,0,0,0, 0,12'h0,64'h0,           0,12'h0,64'h0,           0,0,64'h0);
        tbl[11] = mk(1,0,0,1, 0,12'h0,64'h0,           0,12'h0,64'h0,           1,0,64'h0);
        tbl[12] = mk(0,0,0,0, 0,12'h0,64'h0,           1,12'h341,NPC0,          1,0,64'h0);
        tbl[13] = mk(0,0,0,0, 0,12'h0,64'h0,           1,12'h342,TCAUSE,        1,0,64'h0);
        tbl[14] = mk(0,0,0,0, 0,12'h0,64'h0,           1,12'h300,64'h1880,      1,0,64'h0);
        tbl[15] = mk(0,0,0,0, 0,12'h0,64'h0,           0,12'h0,64'h0,           1,1,64'h8000_0400);
        tbl[16] = mk(1,0,0,1, 0,12'h0,64'h0,           0,12'h0,64'h0,           0,0,64'h0);
        tbl[17] = mk(1,0,0,0, 1,12'h300,64'h88,        1,12'h300,64'h88,        0,0,64'h0);
        tbl[18] = mk(1,1,0,1, 0,12'h0,64'h0,           0,12'h0,64'h0,           1,0,64'h0);
        tbl[19] = mk(0,0,0,0, 0,12'h0,64'h0,           1,12'h341,PC0,           1,0,64'h0);
        tbl[20] = mk(0,0,0,0, 0,12'h0,64'h0,           1,12'h342,64'hB,         1,0,64'h0);
        tbl[21] = mk(0,0,0,0, 0,12'h0,64'h0,           1,12'h300,64'h1880,      1,0,64'h0);
        tbl[22] = mk(0,0,0,0, 0,12'h0,64'h0,           0,12'h0,64'h0,           1,1,64'h8000_0400);
        tbl[23] = mk(1,0,0,1, 0,12'h0,64'h0,           0,12'h0,64'h0,           0,0,64'h0);
        tbl[24] = mk(1,0,0,0, 1,12'h305,64'h8000_0800, 1,12'h305,64'h8000_0800, 0,0,64'h0);

        #12;
        chk("reset_outputs", {o_csr_wen, o_stall, o_flush, o_redirect, o_busy, o_redirect_pc}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].v, tbl[i].ec, tbl[i].mr, tbl[i].ti, tbl[i].wen, tbl[i].wa, tbl[i].wd, PC0, NPC0);
            chk($sformatf("vec%0d_wen", i), o_csr_wen, tbl[i].ew);
            if (tbl[i].ew) chk($sformatf("vec%0d_wr", i), {o_csr_waddr, o_csr_wdata}, {tbl[i].ea, tbl[i].ed});
            chk($sformatf("vec%0d_stall", i), o_stall, tbl[i].es);
            chk($sformatf("vec%0d_redir_flush", i), {o_redirect, o_flush}, {tbl[i].er, tbl[i].er});
            if (tbl[i].er) chk($sformatf("vec%0d_rpc", i), o_redirect_pc, tbl[i].erpc);
        end

        // randomized traffic against the queue model
        addrs[0] = 12'h300; addrs[1] = 12'h304; addrs[2] = 12'h305; addrs[3] = 12'h341; addrs[4] = 12'h342;
        for (int n = 0; n < 600; n++) begin
            rstep($urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, addrs[$urandom_range(0, 4)],
                  {$urandom, $urandom}, {32'h0, $urandom} & ~64'h3, {32'h0, $urandom} & ~64'h3);
        end
        for (int n = 0; n < 6; n++) rstep(0, 0, 0, 0, 0, 12'h0, 64'h0, PC0, NPC0);

        // asynchronous reset in the middle of a trap sequence
        ms = 64'h8;
        rstep(1, 1, 0, 0, 0, 12'h0, 64'h0, PC0, NPC0);
        rstep(0, 0, 0, 0, 0, 12'h0, 64'h0, PC0, NPC0);
        rstep(0, 0, 0, 0, 0, 12'h0, 64'h0, PC0, NPC0);
        rst_n = 1'b0;
        #1;
        chk("midseq_reset_outputs", {o_csr_wen, o_stall, o_flush, o_redirect, o_busy, o_redirect_pc}, '0);
        q.delete();
        pw = 1'b0;
        #1 rst_n = 1'b1;
        for (int n = 0; n < 6; n++) rstep(0, 0, 0, 0, 0, 12'h0, 64'h0, PC0, NPC0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
